// File: rtl/wb_stage_pkg.sv
// Shared definitions for the write-back stage: load-op encodings, reset level and bus widths.
package wb_stage_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'd0,
    LD_LB   = 3'd1,
    LD_LBU  = 3'd2,
    LD_LH   = 3'd3,
    LD_LHU  = 3'd4,
    LD_LW   = 3'd5
  } ld_op_e;

  localparam logic        RstEnable  = 1'b0;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegBus     = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  // Encodings 6 and 7 are reserved and behave as "no load".
  function automatic logic is_load(input logic [2:0] op);
    return (op == LD_LB) || (op == LD_LBU) || (op == LD_LH) || (op == LD_LHU) || (op == LD_LW);
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Combinational load extraction: little-endian byte/halfword select, sign/zero extension and
// misalignment detection for the instruction sitting in WB.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus
) (
  input  logic [2:0]        ld_op,
  input  logic [1:0]        ld_off,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic [DATA_W-1:0] data,
  output logic              misalign
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = dram_rdata[{ld_off, 3'b000} +: 8];
  // Halfword position comes from ld_off[1]; ld_off[0] only matters for misalignment.
  assign half_sel = dram_rdata[{ld_off[1], 4'b0000} +: 16];

  always_comb begin
    data     = '0;
    misalign = 1'b0;
    case (ld_op)
      LD_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_LH: begin
        data     = {{(DATA_W-16){half_sel[15]}}, half_sel};
        misalign = ld_off[0];
      end
      LD_LHU: begin
        data     = {{(DATA_W-16){1'b0}}, half_sel};
        misalign = ld_off[0];
      end
      LD_LW: begin
        data     = dram_rdata;
        misalign = (ld_off != 2'b00);
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB latch with stall/flush, load alignment, register file write port and
// the LL/SC LLbit (present only when WB_LLSC_EN is defined).
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic              mem_wreg,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_ld_op,
  input  logic [1:0]        mem_ld_off,
  input  logic              mem_ll,
  input  logic              mem_sc,
  input  logic [DATA_W-1:0] dram_rdata,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_we,
  output logic              wb_misalign,
  output logic              llbit_o
);

  logic [ADDR_W-1:0] waddr_q;
  logic              wreg_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        ld_op_q;
  logic [1:0]        ld_off_q;
  logic              load_bubble;

  // flush beats everything; a stalled MEM feeding a running WB inserts a bubble.
  assign load_bubble = (rst == RstEnable) || flush || (stall_mem && !stall_wb);

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      waddr_q  <= '0;
      wreg_q   <= 1'b0;
      wdata_q  <= ZeroWord[DATA_W-1:0];
      ld_op_q  <= LD_NONE;
      ld_off_q <= 2'b00;
    end else if (!stall_wb) begin
      waddr_q  <= mem_waddr;
      wreg_q   <= mem_wreg;
      wdata_q  <= mem_wdata;
      ld_op_q  <= mem_ld_op;
      ld_off_q <= mem_ld_off;
    end
  end

  logic [DATA_W-1:0] align_data;
  logic              misalign;

  load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .ld_op     (ld_op_q),
    .ld_off    (ld_off_q),
    .dram_rdata(dram_rdata),
    .data      (align_data),
    .misalign  (misalign)
  );

`ifdef WB_LLSC_EN
  logic ll_q;
  logic sc_q;
  logic llbit_q;
  logic llbit_d;

  always_ff @(posedge clk) begin
    if (load_bubble) begin
      ll_q <= 1'b0;
      sc_q <= 1'b0;
    end else if (!stall_wb) begin
      ll_q <= mem_ll;
      sc_q <= mem_sc;
    end
  end

  always_comb begin
    llbit_d = llbit_q;
    if (!stall_wb) begin
      if (flush) begin
        llbit_d = 1'b0;
      end else if (ll_q) begin
        llbit_d = 1'b1;
      end else if (sc_q && llbit_q) begin
        llbit_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      llbit_q <= 1'b0;
    end else begin
      llbit_q <= llbit_d;
    end
  end

  assign llbit_o = (ll_q || sc_q) ? llbit_d : llbit_q;
`else
  logic unused_llsc;
  assign unused_llsc = mem_ll ^ mem_sc;
  assign llbit_o     = 1'b0;
`endif

  always_comb begin
    wb_wdata = wdata_q;
    if (is_load(ld_op_q)) begin
      wb_wdata = align_data;
    end
`ifdef WB_LLSC_EN
    // SC reports success as a single bit in the destination register.
    if (sc_q) begin
      wb_wdata = {{(DATA_W-1){1'b0}}, llbit_q};
    end
`endif
  end

  assign wb_waddr    = waddr_q;
  assign wb_we       = wreg_q && !misalign;
  assign wb_misalign = misalign;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand-written stall/flush/reset/LL-SC
// sequences, then randomized traffic against a behavioural model.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst, stall_mem, stall_wb, flush, mem_wreg, mem_ll, mem_sc;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata, dram_rdata;
  logic [2:0]    mem_ld_op;
  logic [1:0]    mem_ld_off;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          wb_we, wb_misalign, llbit_o;

  always #5 clk = ~clk;

  wb_stage #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_mem  (stall_mem),
    .stall_wb   (stall_wb),
    .flush      (flush),
    .mem_waddr  (mem_waddr),
    .mem_wreg   (mem_wreg),
    .mem_wdata  (mem_wdata),
    .mem_ld_op  (mem_ld_op),
    .mem_ld_off (mem_ld_off),
    .mem_ll     (mem_ll),
    .mem_sc     (mem_sc),
    .dram_rdata (dram_rdata),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .wb_we      (wb_we),
    .wb_misalign(wb_misalign),
    .llbit_o    (llbit_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: the instruction currently in WB plus the LLbit.
  typedef struct {
    logic        wreg;
    int unsigned waddr;
    logic [31:0] wdata;
    int unsigned op;
    int unsigned off;
    logic        ll;
    logic        sc;
  } instr_t;

  instr_t m;
  logic   m_llbit;

  function automatic instr_t bubble();
    instr_t b;
    b.wreg = 0; b.waddr = 0; b.wdata = 0; b.op = 0; b.off = 0; b.ll = 0; b.sc = 0;
    return b;
  endfunction

  function automatic instr_t from_inputs();
    instr_t i;
    i.wreg = mem_wreg; i.waddr = mem_waddr; i.wdata = mem_wdata;
    i.op = mem_ld_op; i.off = mem_ld_off;
`ifdef WB_LLSC_EN
    i.ll = mem_ll; i.sc = mem_sc;
`else
    i.ll = 0; i.sc = 0;
`endif
    return i;
  endfunction

  function automatic logic next_llbit();
    logic r;
    r = m_llbit;
    if (!stall_wb) begin
      if (flush) r = 0;
      else if (m.ll) r = 1;
      else if (m.sc) r = 0;   // SC always leaves the LLbit clear
    end
    return r;
  endfunction

  function automatic logic exp_misalign();
    if ((m.op == 3 || m.op == 4) && (m.off % 2) != 0) return 1;
    if (m.op == 5 && m.off != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] exp_wdata();
    int b;
`ifdef WB_LLSC_EN
    if (m.sc) return {31'b0, m_llbit};
`endif
    case (m.op)
      1, 2: begin
        b = int'((dram_rdata >> (8 * m.off)) & 32'hFF);
        if (m.op == 1 && b > 127) b -= 256;
        return 32'(b);
      end
      3, 4: begin
        b = int'((dram_rdata >> (8 * (m.off & 2))) & 32'hFFFF);
        if (m.op == 3 && b > 32767) b -= 65536;
        return 32'(b);
      end
      5:       return dram_rdata;
      default: return m.wdata;
    endcase
  endfunction

  task automatic check_outputs(input string tag);
    logic exp_llbit;
    exp_llbit = 0;
`ifdef WB_LLSC_EN
    exp_llbit = (m.ll || m.sc) ? next_llbit() : m_llbit;
`endif
    check({tag, ".we"}, 32'(wb_we), 32'(m.wreg && !exp_misalign()));
    check({tag, ".waddr"}, 32'(wb_waddr), 32'(m.waddr));
    check({tag, ".wdata"}, wb_wdata, exp_wdata());
    check({tag, ".misalign"}, 32'(wb_misalign), 32'(exp_misalign()));
    check({tag, ".llbit"}, 32'(llbit_o), 32'(exp_llbit));
  endtask

  task automatic model_edge();
    logic nl;
    if (!rst) begin
      m = bubble();
      m_llbit = 0;
    end else begin
      nl = next_llbit();
`ifdef WB_LLSC_EN
      m_llbit = nl;
`endif
      if (flush || (stall_mem && !stall_wb)) m = bubble();
      else if (!stall_wb) m = from_inputs();
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic wreg, input logic [4:0] waddr, input logic [31:0] wdata,
                         input logic [2:0] op, input logic [1:0] off, input logic ll,
                         input logic sc);
    mem_wreg = wreg; mem_waddr = waddr; mem_wdata = wdata;
    mem_ld_op = op; mem_ld_off = off; mem_ll = ll; mem_sc = sc;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  off;
    logic [31:0] rdata;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{3'd1, 2'd2, 32'h12F45678, 5'd1,  32'h0,        32'hFFFFFFF4, 1'b1, 1'b0};
    vecs[1]  = '{3'd2, 2'd2, 32'h12F45678, 5'd2,  32'h0,        32'h000000F4, 1'b1, 1'b0};
    vecs[2]  = '{3'd3, 2'd1, 32'h12F45678, 5'd3,  32'h0,        32'h00005678, 1'b0, 1'b1};
    vecs[3]  = '{3'd5, 2'd0, 32'hDEADBEEF, 5'd7,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[4]  = '{3'd3, 2'd2, 32'h80011234, 5'd4,  32'h0,        32'hFFFF8001, 1'b1, 1'b0};
    vecs[5]  = '{3'd4, 2'd0, 32'h12348765, 5'd5,  32'h0,        32'h00008765, 1'b1, 1'b0};
    vecs[6]  = '{3'd5, 2'd2, 32'hDEADBEEF, 5'd6,  32'h0,        32'hDEADBEEF, 1'b0, 1'b1};
    vecs[7]  = '{3'd6, 2'd3, 32'hFFFFFFFF, 5'd8,  32'h0BADCAFE, 32'h0BADCAFE, 1'b1, 1'b0};
    vecs[8]  = '{3'd1, 2'd3, 32'h7F000000, 5'd9,  32'h0,        32'h0000007F, 1'b1, 1'b0};
    vecs[9]  = '{3'd0, 2'd1, 32'hFFFFFFFF, 5'd10, 32'h13579BDF, 32'h13579BDF, 1'b1, 1'b0};
    vecs[10] = '{3'd4, 2'd3, 32'hABCD0000, 5'd11, 32'h0,        32'h0000ABCD, 1'b0, 1'b1};
    vecs[11] = '{3'd1, 2'd0, 32'h00000080, 5'd12, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0};

    // Reset held for two edges with a register write waiting in MEM.
    rst = 0; stall_mem = 0; stall_wb = 0; flush = 0; dram_rdata = 32'hFFFFFFFF;
    set_mem(1, 5'd3, 32'h55, 3'd0, 2'd0, 0, 0);
    step();
    step();
    check("reset.we", 32'(wb_we), 32'h0);
    check("reset.waddr", 32'(wb_waddr), 32'h0);
    check("reset.wdata", wb_wdata, 32'h0);
    check("reset.misalign", 32'(wb_misalign), 32'h0);
    check("reset.llbit", 32'(llbit_o), 32'h0);
    rst = 1;

    for (int i = 0; i < 12; i++) begin
      set_mem(1, vecs[i].waddr, vecs[i].wdata, vecs[i].op, vecs[i].off, 0, 0);
      step();
      dram_rdata = vecs[i].rdata;
      #1;
      check($sformatf("vec%0d.wdata", i), wb_wdata, vecs[i].exp_data);
      check($sformatf("vec%0d.we", i), 32'(wb_we), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d.misalign", i), 32'(wb_misalign), 32'(vecs[i].exp_mis));
      check($sformatf("vec%0d.waddr", i), 32'(wb_waddr), 32'(vecs[i].waddr));
    end

    // MEM stalled while WB runs: a bubble follows.
    set_mem(1, 5'd9, 32'h99, 3'd0, 2'd0, 0, 0);
    stall_mem = 1;
    step();
    check("stall_mem.we", 32'(wb_we), 32'h0);
    stall_mem = 0;

    // WB hold keeps presenting the same write.
    set_mem(1, 5'd4, 32'h5, 3'd0, 2'd0, 0, 0);
    step();
    stall_wb = 1;
    set_mem(1, 5'd5, 32'h77, 3'd0, 2'd0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("hold%0d.wdata", i), wb_wdata, 32'h5);
      check($sformatf("hold%0d.we", i), 32'(wb_we), 32'h1);
      step();
    end
    check("hold_last.wdata", wb_wdata, 32'h5);
    stall_wb = 0;
    step();
    check("release.wdata", wb_wdata, 32'h77);
    check("release.waddr", 32'(wb_waddr), 32'h5);

    // flush together with stall_wb still loads a bubble.
    set_mem(1, 5'd10, 32'hAA, 3'd0, 2'd0, 0, 0);
    stall_wb = 1; flush = 1;
    step();
    stall_wb = 0; flush = 0;
    check("flush_stall.we", 32'(wb_we), 32'h0);
    check("flush_stall.wdata", wb_wdata, 32'h0);

    // Reset with a load in WB discards it.
    set_mem(1, 5'd13, 32'h0, 3'd5, 2'd0, 0, 0);
    step();
    rst = 0;
    step();
    dram_rdata = 32'hCAFEF00D;
    #1;
    check("reset_mid.we", 32'(wb_we), 32'h0);
    check("reset_mid.wdata", wb_wdata, 32'h0);
    rst = 1;

`ifdef WB_LLSC_EN
    set_mem(1, 5'd2, 32'h0, 3'd5, 2'd0, 1, 0);
    step();
    check("ll.llbit_fwd", 32'(llbit_o), 32'h1);
    set_mem(1, 5'd3, 32'h1234, 3'd0, 2'd0, 0, 1);
    step();
    check("sc_ok.wdata", wb_wdata, 32'h1);
    check("sc_ok.llbit_fwd", 32'(llbit_o), 32'h0);
    set_mem(0, 5'd0, 32'h0, 3'd0, 2'd0, 0, 0);
    step();
    check("after_sc.llbit", 32'(llbit_o), 32'h0);
    set_mem(1, 5'd2, 32'h0, 3'd5, 2'd0, 1, 0);
    step();
    flush = 1;
    step();
    flush = 0;
    set_mem(1, 5'd3, 32'h1234, 3'd0, 2'd0, 0, 1);
    step();
    check("sc_fail.wdata", wb_wdata, 32'h0);
    check("sc_fail.we", 32'(wb_we), 32'h1);
`else
    set_mem(1, 5'd2, 32'h0, 3'd5, 2'd0, 1, 0);
    step();
    dram_rdata = 32'h600DD00D;
    #1;
    check("ll_as_lw.wdata", wb_wdata, 32'h600DD00D);
    check("ll_as_lw.llbit", 32'(llbit_o), 32'h0);
    set_mem(1, 5'd3, 32'h1234, 3'd0, 2'd0, 0, 1);
    step();
    check("sc_plain.wdata", wb_wdata, 32'h1234);
    check("sc_plain.llbit", 32'(llbit_o), 32'h0);
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 63) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      stall_mem  = ($urandom_range(0, 5) == 0);
      stall_wb   = ($urandom_range(0, 5) == 0);
      mem_wreg   = 1'($urandom);
      mem_waddr  = 5'($urandom);
      mem_wdata  = $urandom;
      mem_ld_op  = 3'($urandom_range(0, 7));
      mem_ld_off = 2'($urandom);
      mem_ll     = ($urandom_range(0, 5) == 0);
      mem_sc     = !mem_ll && ($urandom_range(0, 5) == 0);
`ifdef WB_LLSC_EN
      if (mem_ll) mem_ld_op = 3'd5;
      if (mem_sc) mem_ld_op = 3'd0;
`endif
      dram_rdata = $urandom;
      #1;
      check_outputs($sformatf("rand%0d", n));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage integer pipeline. It latches the MEM-stage result at each clock edge and honours stall and flush. It aligns and sign- or zero-extends load data returned by the synchronous data RAM, then drives the register file write port (`wb_waddr`, `wb_wdata`, `wb_we`). It also owns the LLbit used by LL/SC.

## Interface
Parameters:
- `DATA_W`, default 32: datapath width.
- `ADDR_W`, default 5: register address width.

Ports:
- `clk`  in  1: pipeline clock.
- `rst`  in  1: reset, synchronous and active-low (`rst == 0` resets on the rising edge of `clk`).
- `stall_mem`  in  1: MEM stage is stalled this cycle.
- `stall_wb`  in  1: WB stage is stalled this cycle.
- `flush`  in  1: exception/eret flush; kills the incoming MEM instruction.
- `mem_waddr`  in  ADDR_W: destination register.
- `mem_wreg`  in  1: instruction writes a register.
- `mem_wdata`  in  DATA_W: ALU/move result for non-loads.
- `mem_ld_op`  in  3: load type; 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; 6–7 reserved, treated as none.
- `mem_ld_off`  in  2: byte address bits [1:0] of the load.
- `mem_ll`  in  1: instruction is LL.
- `mem_sc`  in  1: instruction is SC.
- `dram_rdata`  in  DATA_W: RAM read word; valid in the WB cycle of a load.
- `wb_waddr`  out  ADDR_W: register file write address.
- `wb_wdata`  out  DATA_W: register file write data.
- `wb_we`  out  1: register file write enable.
- `wb_misalign`  out  1: the instruction in WB is a misaligned load.
- `llbit_o`  out  1: LLbit as seen by MEM, with forwarding from WB.

## Operation
- **WB latch.** On the clock edge when `rst == 1`, the latch takes one of four actions, in this priority order:
  - `flush`: load a bubble.
  - `stall_mem && !stall_wb`: load a bubble.
  - `stall_wb`: hold the current contents.
  - Otherwise: capture all `mem_*` inputs.
- **Bubble.** A bubble has `wreg = 0`, `ld_op = 0`, `ll = 0`, `sc = 0`, and all other fields 0.
- **Load extraction.** Little-endian: byte k = `dram_rdata[8k+7:8k]`. The selected byte or halfword is extended as follows:
  - LB / LH: sign-extended to DATA_W.
  - LBU / LHU: zero-extended to DATA_W.
  - LW: the whole word.
- **Misalignment.** A load is misaligned when LH/LHU has `ld_off[0] == 1`, or LW has `ld_off != 0`. A misaligned load forces `wb_we = 0` and `wb_misalign = 1`.
- **Non-load data.** When `ld_op == 0`, `wb_wdata` = the latched `wdata`.
- **Write enable.** `wb_we` = latched `wreg && !misalign`. A write to r0 is still presented; the register file discards it.
- **LLbit update.** When the instruction in WB is not stalled (`!stall_wb`):
  - LL sets the LLbit.
  - `flush` clears it; flush has priority over LL.
  - SC with the LLbit set clears it (see Configuration).
- **Outputs.** `wb_waddr`, `wb_wdata` and `wb_we` are combinational from the latch and `dram_rdata`; `wb_misalign` is combinational from the latch.
- **`llbit_o` forwarding.** `llbit_o` = the next-state LLbit when the WB latch holds LL or SC, otherwise the current LLbit.

## Timing
- **Latency.** MEM inputs appear on the `wb_*` outputs 1 cycle after capture.
- **Load data.** `dram_rdata` is used in the same cycle it arrives; the path is combinational to `wb_wdata`.
- **Register file.** Its same-cycle write-to-read bypass removes the need for a WB→ID forward in this block.
- **Reset.** While `rst == 0`, at the edge the latch loads a bubble and LLbit is set to 0. After reset: `wb_we = 0`, `wb_waddr = 0`, `wb_wdata = 0`, `wb_misalign = 0`, `llbit_o = 0`.
- **Reset mid-operation.** A pending load is discarded and no write occurs.
- **`flush` and `stall_wb` together.** `flush` wins: a bubble is loaded.
- **Held instruction.** While `stall_wb` holds, the held instruction keeps driving `wb_we` every cycle. This is idempotent.
- **LLbit during a hold.** The LLbit updates once, on the first edge after the hold releases.

## Configuration
- **`WB_LLSC_EN` defined.**
  - LLbit register and `llbit_o` are present.
  - SC writes `{31'b0, LLbit}` to its destination. With the LLbit set it returns 1 and clears the LLbit; with the LLbit clear it returns 0.
- **`WB_LLSC_EN` undefined.**
  - No LLbit register.
  - `llbit_o` is tied to 0.
  - `mem_ll` and `mem_sc` are ignored: LL behaves as LW, and SC writes `mem_wdata` unchanged.

## Structure
- **Shared package / `Defines.vh`.** Holds the load-op encodings (`LD_NONE`, `LD_LB`, `LD_LBU`, `LD_LH`, `LD_LHU`, `LD_LW`), `RstEnable`, `ZeroWord`, `RegAddrBus` and `RegBus`.
- **Sub-module `load_align`.** A purely combinational unit for extraction, extension and misalignment detection. Inputs: `ld_op`, `ld_off`, `dram_rdata`. Outputs: `data`, `misalign`.
- **Top level.** `wb_stage` holds the latch, the LLbit and the output muxing.

## Test plan
- Hold `rst = 0` for 2 cycles while `mem_wreg = 1`, `mem_waddr = 3`. Expect `wb_we = 0`, all outputs 0, `llbit_o = 0`.
- LB with `ld_off = 2`, `dram_rdata = 0x12F45678`. Expect `wb_wdata = 0xFFFFFFF4`. The same load as LBU gives `0x000000F4`.
- LH with `ld_off = 1`. Expect `wb_misalign = 1` and `wb_we = 0`. LW with `ld_off = 0`, `dram_rdata = 0xDEADBEEF`, `waddr = 7`. Expect a write of `0xDEADBEEF` to r7.
- `stall_mem = 1`, `stall_wb = 0`. Expect a bubble next cycle (`wb_we = 0`). Then `stall_wb = 1` with an ALU result `0x5`. Expect `wb_wdata` held at 5 until release.
- `WB_LLSC_EN`: LL, then SC, no flush. Expect SC writes 1 and `llbit_o` returns to 0. LL, then `flush`, then SC. Expect SC writes 0.
- `flush` asserted together with `stall_wb` while MEM holds a valid write. Expect a bubble next cycle and no register write.
